// File: rtl/arb_rr8_dec_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes and FSM state type.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_rr8_dec_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface arb_rr8_dec_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             preempt;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  preempt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output preempt
    );

endinterface

// File: rtl/arb_rr8_dec_onehot_dec3to8.sv
// Combinational 3-to-8 one-hot decoder with enable; all zeros when disabled.
module onehot_dec3to8
    import arb_pkg::*;
(
    input  logic             en,
    input  logic [IDX_W-1:0] sel,
    output logic [N_REQ-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/arb_rr8_dec.sv
// 8-way round-robin arbiter with bounded hold time; the grant vector is the
// one-hot decode of the registered winning index.
module arb_rr8_dec
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    arb_rr8_dec_if.slave  bus
);

    localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] hold_cnt;
    logic             preempt_q;
    logic             valid;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then undo the rotation.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [IDX_W-1:0]   off;
        dbl = {r, r} >> p;
        rot = dbl[N_REQ-1:0];
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
        return p + off;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            idx       <= '0;
            hold_cnt  <= '0;
            preempt_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    preempt_q <= 1'b0;
                    if (|bus.req) begin
                        idx      <= rr_pick(bus.req, ptr);
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!bus.req[idx]) begin
                        state     <= IDLE;
                        ptr       <= idx + IDX_W'(1);
                        hold_cnt  <= '0;
                        preempt_q <= 1'b0;
                    end else if (hold_cnt == CNT_LAST) begin
                        // Forced release: ptr moves past idx so a persistent requester drops to lowest priority.
                        state     <= IDLE;
                        ptr       <= idx + IDX_W'(1);
                        hold_cnt  <= '0;
                        preempt_q <= 1'b1;
                    end else begin
                        hold_cnt  <= hold_cnt + CNT_W'(1);
                        preempt_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    preempt_q <= 1'b0;
                end
            endcase
        end
    end

    assign valid         = (state == GRANT);
    assign bus.gnt_valid = valid;
    assign bus.gnt_idx   = valid ? idx : '0;
    assign bus.preempt   = preempt_q;

    onehot_dec3to8 u_dec (
        .en  (valid),
        .sel (idx),
        .y   (bus.gnt)
    );

endmodule

// File: tb/tb_arb_rr8_dec.sv
// Directed self-checking bench for arb_rr8_dec, using a HOLD_MAX=16 and a HOLD_MAX=4 instance.
module tb_arb_rr8_dec;
    import arb_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    arb_rr8_dec_if if16 ();
    arb_rr8_dec_if if4 ();

    arb_rr8_dec #(.HOLD_MAX(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16.slave)
    );

    arb_rr8_dec #(.HOLD_MAX(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.slave)
    );

    logic [12:0] obs16;
    logic [12:0] obs4;
    assign obs16 = {if16.gnt, if16.gnt_idx, if16.gnt_valid, if16.preempt};
    assign obs4  = {if4.gnt, if4.gnt_idx, if4.gnt_valid, if4.preempt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {gnt, gnt_idx, gnt_valid, preempt} for a given grant situation.
    function automatic logic [12:0] mk_exp(input int idx, input bit valid, input bit pre);
        logic [7:0] g;
        logic [2:0] i;
        g = valid ? (8'(1) << idx) : 8'h00;
        i = valid ? 3'(idx) : 3'd0;
        return {g, i, valid, pre};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        if4.req  = 8'h00;
        if16.req = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] e;
        rst_n    = 1'b0;
        if4.req  = 8'hFF;
        if16.req = 8'hFF;
        #12;
        e = mk_exp(0, 0, 0);
        n_cmp++;
        if (obs4 !== e) begin
            n_err++;
            $display("[TB] FAIL reset_hold_dut4: got %h want %h", obs4, e);
        end
        n_cmp++;
        if (obs16 !== e) begin
            n_err++;
            $display("[TB] FAIL reset_hold_dut16: got %h want %h", obs16, e);
        end
        step();
        rst_n = 1'b1;
        step();
        e = mk_exp(0, 1, 0);
        n_cmp++;
        if (obs4 !== e) begin
            n_err++;
            $display("[TB] FAIL reset_first_grant_dut4: got %h want %h", obs4, e);
        end
        n_cmp++;
        if (obs16 !== e) begin
            n_err++;
            $display("[TB] FAIL reset_first_grant_dut16: got %h want %h", obs16, e);
        end
        if4.req  = 8'h00;
        if16.req = 8'h00;
        step();
        step();
    endtask

    task automatic test_single_hold();
        logic [12:0] e;
        do_reset();
        if16.req = 8'h01;
        e = mk_exp(0, 0, 0);
        n_cmp++;
        if (obs16 !== e) begin
            n_err++;
            $display("[TB] FAIL single_before_edge: got %h want %h", obs16, e);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            e = mk_exp(0, 1, 0);
            n_cmp++;
            if (obs16 !== e) begin
                n_err++;
                $display("[TB] FAIL single_hold_cyc%0d: got %h want %h", c, obs16, e);
            end
        end
        if16.req = 8'h00;
        for (int c = 0; c < 3; c++) begin
            step();
            e = mk_exp(0, 0, 0);
            n_cmp++;
            if (obs16 !== e) begin
                n_err++;
                $display("[TB] FAIL single_after_cyc%0d: got %h want %h", c, obs16, e);
            end
        end
    endtask

    task automatic test_timeout_rotation();
        logic [12:0] e;
        do_reset();
        if4.req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                e = mk_exp(g % 8, 1, 0);
                n_cmp++;
                if (obs4 !== e) begin
                    n_err++;
                    $display("[TB] FAIL timeout_grant%0d_cyc%0d: got %h want %h", g, c, obs4, e);
                end
            end
            step();
            e = mk_exp(0, 0, 1);
            n_cmp++;
            if (obs4 !== e) begin
                n_err++;
                $display("[TB] FAIL timeout_gap%0d: got %h want %h", g, obs4, e);
            end
        end
        if4.req = 8'h00;
        step();
    endtask

    task automatic test_rotating_priority();
        logic [12:0] e;
        do_reset();
        if4.req = 8'h04;
        step();
        e = mk_exp(2, 1, 0);
        n_cmp++;
        if (obs4 !== e) begin
            n_err++;
            $display("[TB] FAIL rotate_grant2: got %h want %h", obs4, e);
        end
        if4.req = 8'h00;
        step();
        if4.req = 8'h22;
        step();
        e = mk_exp(5, 1, 0);
        n_cmp++;
        if (obs4 !== e) begin
            n_err++;
            $display("[TB] FAIL rotate_grant5: got %h want %h", obs4, e);
        end
        if4.req = 8'h02;
        step();
        e = mk_exp(0, 0, 0);
        n_cmp++;
        if (obs4 !== e) begin
            n_err++;
            $display("[TB] FAIL rotate_release5: got %h want %h", obs4, e);
        end
        step();
        e = mk_exp(1, 1, 0);
        n_cmp++;
        if (obs4 !== e) begin
            n_err++;
            $display("[TB] FAIL rotate_grant1: got %h want %h", obs4, e);
        end
        if4.req = 8'h00;
        step();
    endtask

    task automatic test_wrap();
        logic [12:0] e;
        do_reset();
        if4.req = 8'h80;
        step();
        e = mk_exp(7, 1, 0);
        n_cmp++;
        if (obs4 !== e) begin
            n_err++;
            $display("[TB] FAIL wrap_grant7: got %h want %h", obs4, e);
        end
        if4.req = 8'h00;
        step();
        if4.req = 8'h81;
        step();
        e = mk_exp(0, 1, 0);
        n_cmp++;
        if (obs4 !== e) begin
            n_err++;
            $display("[TB] FAIL wrap_grant0: got %h want %h", obs4, e);
        end
        if4.req = 8'h80;
        step();
        step();
        e = mk_exp(7, 1, 0);
        n_cmp++;
        if (obs4 !== e) begin
            n_err++;
            $display("[TB] FAIL wrap_regrant7: got %h want %h", obs4, e);
        end
        if4.req = 8'h00;
        step();
    endtask

    task automatic test_reset_mid_grant();
        logic [12:0] e;
        do_reset();
        if4.req = 8'h10;
        step();
        e = mk_exp(4, 1, 0);
        n_cmp++;
        if (obs4 !== e) begin
            n_err++;
            $display("[TB] FAIL midrst_grant4: got %h want %h", obs4, e);
        end
        #1;
        rst_n = 1'b0;
        #1;
        e = mk_exp(0, 0, 0);
        n_cmp++;
        if (obs4 !== e) begin
            n_err++;
            $display("[TB] FAIL midrst_async_clear: got %h want %h", obs4, e);
        end
        #4;
        rst_n   = 1'b1;
        if4.req = 8'h18;
        step();
        e = mk_exp(3, 1, 0);
        n_cmp++;
        if (obs4 !== e) begin
            n_err++;
            $display("[TB] FAIL midrst_grant3: got %h want %h", obs4, e);
        end
        if4.req = 8'h00;
        step();
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        if4.req  = 8'h00;
        if16.req = 8'h00;
        test_reset();
        test_single_hold();
        test_timeout_rotation();
        test_rotating_priority();
        test_wrap();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
